// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame width and
// the clocks-per-oversample-tick divider calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  // Clocks per oversample tick, integer-truncated.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte plus status strobes out.
// The master modport is the receiver itself; the slave modport is its consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] dout;
  logic       d_rdy;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (input rx, output dout, d_rdy, frame_err, parity_err, busy);
  modport slave  (output rx, input dout, d_rdy, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clock tick every DIV clocks, phase restarted by clr.
module uart_baud_gen #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with start-bit validation and break handling.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input logic        clk,
  input logic        rst,
  uart_rx_if.master  bus
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  uart_state_e          state, state_nxt;
  logic [TW-1:0]        tcnt, tcnt_nxt;
  logic [BW-1:0]        bcnt, bcnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] dout, dout_nxt;
  logic                 d_rdy, d_rdy_nxt;
  logic                 frame_err, frame_err_nxt;
  logic                 rx_p0, rx_s, rx_s_d, fall;
  logic                 tick;

  // Stage p0 -> s: two-flop synchroniser plus edge history (data path, not reset)
  always_ff @(posedge clk) begin
    rx_p0  <= bus.rx;
    rx_s   <= rx_p0;
    rx_s_d <= rx_s;
  end

  assign fall = rx_s_d & ~rx_s;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == IDLE) && fall),
    .tick (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_nxt;
  logic parity_err, parity_err_nxt;
`endif

  always_comb begin
    state_nxt     = state;
    tcnt_nxt      = tcnt;
    bcnt_nxt      = bcnt;
    shreg_nxt     = shreg;
    dout_nxt      = dout;
    d_rdy_nxt     = 1'b0;
    frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt    = par_bad;
    parity_err_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          tcnt_nxt  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt == T_HALF) begin
            tcnt_nxt  = '0;
            bcnt_nxt  = '0;
            // A line back high at mid start bit is a glitch, dropped silently.
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt == T_FULL) begin
            tcnt_nxt  = '0;
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              bcnt_nxt = bcnt + BW'(1);
            end
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tcnt == T_FULL) begin
            tcnt_nxt    = '0;
            par_bad_nxt = rx_s ^ (^shreg);
            state_nxt   = STOP;
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tcnt == T_FULL) begin
            tcnt_nxt = '0;
            if (rx_s) begin
              state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err_nxt = 1'b1;
              end else begin
                dout_nxt  = shreg;
                d_rdy_nxt = 1'b1;
              end
`else
              dout_nxt  = shreg;
              d_rdy_nxt = 1'b1;
`endif
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = WAIT_HIGH;
            end
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off start detection until a break / stuck-low line releases.
        if (rx_s) begin
          state_nxt = IDLE;
          tcnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        tcnt_nxt  = '0;
      end
    endcase
  end

  // Stage: control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      dout      <= '0;
      d_rdy     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      tcnt      <= tcnt_nxt;
      bcnt      <= bcnt_nxt;
      dout      <= dout_nxt;
      d_rdy     <= d_rdy_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nxt;
      parity_err <= parity_err_nxt;
    end
  end
  assign bus.parity_err = parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.dout      = dout;
  assign bus.d_rdy     = d_rdy;
  assign bus.frame_err = frame_err;
  assign bus.busy      = (state != IDLE);

endmodule
